// File: rtl/init_pulse_sequencer_pkg.sv
// Shared types and release-time helper for the staggered init-pulse sequencer.
// Imported by both the RTL and the testbench.
package init_seq_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FINISH = 2'd1,
      IDLE   = 2'd2
   } state_e;

   // Counted edge after which channel k drops its init line.
   function automatic int release_time(input int k, input int pulse_len, input int stagger);
      return pulse_len + k * stagger;
   endfunction

endpackage

// File: rtl/init_pulse_sequencer_if.sv
// Control/status bundle of the init-pulse sequencer.
// The controller (master) drives hold/rearm; the sequencer (slave) drives the init lines and status.
interface init_pulse_sequencer_if #(
   parameter int NUM_CH = 4
) ();

   logic              hold;
   logic              rearm;
   logic [NUM_CH-1:0] init_out;
   logic              busy;
   logic              done;

   modport master (
      output hold,
      output rearm,
      input  init_out,
      input  busy,
      input  done
   );

   modport slave (
      input  hold,
      input  rearm,
      output init_out,
      output busy,
      output done
   );

endinterface

// File: rtl/init_pulse_sequencer.sv
// Holds NUM_CH init lines high after reset and releases them one by one,
// channel k falling PULSE_LEN + k*STAGGER counted (non-held) cycles after release.
module init_pulse_sequencer
   import init_seq_pkg::*;
#(
   parameter int PULSE_LEN = 2,
   parameter int NUM_CH    = 4,
   parameter int STAGGER   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   init_pulse_sequencer_if.slave bus
);

   localparam int T_LAST = release_time(NUM_CH - 1, PULSE_LEN, STAGGER);
   localparam int CNT_W  = (T_LAST < 1) ? 1 : $clog2(T_LAST + 1);

   localparam logic [CNT_W-1:0] T_LAST_C = CNT_W'(T_LAST);

   if (PULSE_LEN < 1) begin : g_bad_pulse_len
      $error("init_pulse_sequencer: PULSE_LEN must be >= 1");
   end
   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("init_pulse_sequencer: NUM_CH must be >= 1");
   end
   if (STAGGER < 0) begin : g_bad_stagger
      $error("init_pulse_sequencer: STAGGER must be >= 0");
   end

   state_e             state_q,    state_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [NUM_CH-1:0]  init_out_q, init_out_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;

   logic [CNT_W-1:0]   cnt_inc;
   logic [NUM_CH-1:0]  still_high;

   // Saturating increment: the counter parks at T_LAST and never wraps.
   assign cnt_inc = (cnt_q == T_LAST_C) ? cnt_q : cnt_q + CNT_W'(1);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam logic [CNT_W-1:0] T_K = CNT_W'(release_time(k, PULSE_LEN, STAGGER));
      assign still_high[k] = (cnt_inc < T_K);
   end

   always_comb begin
      // NOTE: every _d gets a default before the case, so no path leaves a signal unassigned and no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      init_out_d = init_out_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         RUN: begin
            if (!bus.hold) begin
               cnt_d      = cnt_inc;
               init_out_d = still_high;
               busy_d     = |still_high;
               if (cnt_inc == T_LAST_C) begin
                  init_out_d = '0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  state_d    = FINISH;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         IDLE: begin
            init_out_d = '0;
            busy_d     = 1'b0;
            if (bus.rearm) begin
               cnt_d      = '0;
               init_out_d = '1;
               busy_d     = 1'b1;
               state_d    = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         init_out_q <= '1;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         init_out_q <= init_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.init_out = init_out_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_init_pulse_sequencer.sv
// Directed bench for init_pulse_sequencer: default config (hold, rearm, mid-sequence reset),
// STAGGER=0 config, and the single-channel legacy config.
module tb_init_pulse_sequencer;
   import init_seq_pkg::*;

   logic clk;
   logic rst0_n;
   logic rst1_n;

   int total_cnt = 0;
   int pass_cnt  = 0;

   init_pulse_sequencer_if #(.NUM_CH(4)) bus0 ();
   init_pulse_sequencer_if #(.NUM_CH(3)) bus1 ();
   init_pulse_sequencer_if #(.NUM_CH(1)) bus2 ();

   init_pulse_sequencer #(.PULSE_LEN(2), .NUM_CH(4), .STAGGER(3)) dut0 (
      .clk   (clk),
      .reset (rst0_n),
      .bus   (bus0)
   );

   init_pulse_sequencer #(.PULSE_LEN(4), .NUM_CH(3), .STAGGER(0)) dut1 (
      .clk   (clk),
      .reset (rst1_n),
      .bus   (bus1)
   );

   init_pulse_sequencer #(.PULSE_LEN(2), .NUM_CH(1), .STAGGER(0)) dut2 (
      .clk   (clk),
      .reset (rst1_n),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check0(input string tag, input logic [3:0] io, input logic bz, input logic dn);
      check({tag, ".init"}, 32'(bus0.init_out), 32'(io));
      check({tag, ".busy"}, 32'(bus0.busy), 32'(bz));
      check({tag, ".done"}, 32'(bus0.done), 32'(dn));
   endtask

   initial begin
      rst0_n     = 1'b0;
      rst1_n     = 1'b0;
      bus0.hold  = 1'b0;
      bus0.rearm = 1'b0;
      bus1.hold  = 1'b0;
      bus1.rearm = 1'b0;
      bus2.hold  = 1'b0;
      bus2.rearm = 1'b0;

      // ---------------- default config: T = 2,5,8,11 ----------------
      tick(2);
      check0("d0_reset", 4'b1111, 1'b1, 1'b0);
      rst0_n = 1'b1;
      tick(1);  check0("d0_E1",  4'b1111, 1'b1, 1'b0);
      tick(1);  check0("d0_E2",  4'b1110, 1'b1, 1'b0);
      tick(2);  check0("d0_E4",  4'b1110, 1'b1, 1'b0);
      tick(1);  check0("d0_E5",  4'b1100, 1'b1, 1'b0);
      tick(2);  check0("d0_E7",  4'b1100, 1'b1, 1'b0);
      tick(1);  check0("d0_E8",  4'b1000, 1'b1, 1'b0);
      tick(2);  check0("d0_E10", 4'b1000, 1'b1, 1'b0);
      tick(1);  check0("d0_E11", 4'b0000, 1'b0, 1'b1);
      tick(1);  check0("d0_E12", 4'b0000, 1'b0, 1'b0);
      tick(3);  check0("d0_idle", 4'b0000, 1'b0, 1'b0);

      // ---------------- rearm, hold 3 edges after E3, rearm ignored at E4 ----------------
      bus0.rearm = 1'b1;
      bus0.hold  = 1'b1;
      tick(1);  check0("rearm", 4'b1111, 1'b1, 1'b0);
      bus0.rearm = 1'b0;
      bus0.hold  = 1'b0;
      tick(1);  check0("h_w1", 4'b1111, 1'b1, 1'b0);
      tick(1);  check0("h_w2", 4'b1110, 1'b1, 1'b0);
      tick(1);  check0("h_w3", 4'b1110, 1'b1, 1'b0);
      bus0.hold = 1'b1;
      tick(1);  check0("h_w4_held", 4'b1110, 1'b1, 1'b0);
      tick(1);  check0("h_w5_held", 4'b1110, 1'b1, 1'b0);
      tick(1);  check0("h_w6_held", 4'b1110, 1'b1, 1'b0);
      bus0.hold  = 1'b0;
      bus0.rearm = 1'b1;
      tick(1);  check0("h_w7_rearm_ign", 4'b1110, 1'b1, 1'b0);
      bus0.rearm = 1'b0;
      tick(1);  check0("h_w8", 4'b1100, 1'b1, 1'b0);
      tick(2);  check0("h_w10", 4'b1100, 1'b1, 1'b0);
      tick(1);  check0("h_w11", 4'b1000, 1'b1, 1'b0);
      tick(2);  check0("h_w13", 4'b1000, 1'b1, 1'b0);
      tick(1);  check0("h_w14", 4'b0000, 1'b0, 1'b1);
      bus0.rearm = 1'b1;
      tick(1);  check0("h_w15_finish", 4'b0000, 1'b0, 1'b0);
      bus0.rearm = 1'b0;
      tick(1);  check0("h_w16_idle", 4'b0000, 1'b0, 1'b0);

      // ---------------- reset mid-sequence at E6 ----------------
      bus0.rearm = 1'b1;
      tick(1);
      bus0.rearm = 1'b0;
      tick(6);  check0("r_E6", 4'b1100, 1'b1, 1'b0);
      #2;
      rst0_n = 1'b0;
      #1;       check0("r_async", 4'b1111, 1'b1, 1'b0);
      tick(1);
      rst0_n = 1'b1;
      tick(1);  check0("r_E1", 4'b1111, 1'b1, 1'b0);
      tick(1);  check0("r_E2", 4'b1110, 1'b1, 1'b0);

      // ---------------- STAGGER=0 (N=3,P=4) and legacy (N=1,P=2) ----------------
      check("s0_reset.init", 32'(bus1.init_out), 32'h7);
      check("lg_reset.init", 32'(bus2.init_out), 32'h1);
      check("lg_reset.busy", 32'(bus2.busy), 32'h1);
      rst1_n = 1'b1;
      tick(1);
      check("lg_E1.init", 32'(bus2.init_out), 32'h1);
      check("s0_E1.init", 32'(bus1.init_out), 32'h7);
      tick(1);
      check("lg_E2.init", 32'(bus2.init_out), 32'h0);
      check("lg_E2.done", 32'(bus2.done), 32'h1);
      check("lg_E2.busy", 32'(bus2.busy), 32'h0);
      check("s0_E2.init", 32'(bus1.init_out), 32'h7);
      tick(1);
      check("lg_E3.done", 32'(bus2.done), 32'h0);
      check("s0_E3.init", 32'(bus1.init_out), 32'h7);
      check("s0_E3.done", 32'(bus1.done), 32'h0);
      tick(1);
      check("s0_E4.init", 32'(bus1.init_out), 32'h0);
      check("s0_E4.done", 32'(bus1.done), 32'h1);
      check("s0_E4.busy", 32'(bus1.busy), 32'h0);
      tick(1);
      check("s0_E5.done", 32'(bus1.done), 32'h0);
      check("s0_E5.init", 32'(bus1.init_out), 32'h0);
      check("lg_E5.init", 32'(bus2.init_out), 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/init_pulse_sequencer.md
Name: init_pulse_sequencer

Overview:
- Parametrised successor of the team's 1-then-0 power-on initialiser.
- Drives NUM_CH init lines high at reset, then releases them one by one, staggered: channel k falls PULSE_LEN + k*STAGGER counted cycles after reset release.
- Supports a freeze input (hold), a software re-arm, and busy/done status.
- Sits at the top of the irrigation controller and sequences valve/sensor sub-block initialisation so the pumps do not inrush simultaneously.

Parameters:
- PULSE_LEN, 2, cycles all channels stay high after reset release; must be >= 1.
- NUM_CH, 4, number of init output lines; must be >= 1.
- STAGGER, 3, cycles between successive channel releases; 0 releases all channels together.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- hold  in  1  when 1, freezes the sequence counter.
- rearm  in  1  when 1 in IDLE, restarts the sequence.
- init_out  out  NUM_CH  init lines; 1 = hold target in init.
- busy  out  1  1 while any init_out bit is 1.
- done  out  1  one-cycle pulse when the last channel releases.

Behaviour:
- Reset assertion (asynchronous): init_out = all 1s, busy=1, done=0, cnt=0, state=RUN.
- Derived constants:
  - T_k = PULSE_LEN + k*STAGGER.
  - T_LAST = T_(NUM_CH-1).
  - cnt width = $clog2(T_LAST+1).
- States: RUN, FINISH, IDLE.
- RUN:
  - Each rising edge with hold==0: cnt <= cnt+1.
  - hold==1: cnt, init_out and state unchanged.
  - All outputs are registered: init_out[k] <= (cnt_next < T_k).
  - When cnt_next == T_LAST: init_out <= 0, busy <= 0, done <= 1, state <= FINISH.
- FINISH: done <= 0; state <= IDLE. This holds regardless of hold and rearm.
- IDLE:
  - Outputs held at 0.
  - rearm==1 at an edge: cnt <= 0, init_out <= all 1s, busy <= 1, state <= RUN. hold on that same edge has no effect on the re-arm.
- Timing: counting edges E1, E2, ... after reset release, excluding held edges, init_out[k] falls immediately after edge E(T_k). done is high for exactly the cycle after E(T_LAST).
- rearm in RUN or FINISH is ignored. It is not queued.
- hold in FINISH or IDLE has no effect.
- Reset mid-sequence: returns immediately to all 1s and restarts from cnt=0 on release.
- STAGGER=0: all channels fall on E(PULSE_LEN) together.
- NUM_CH=1, PULSE_LEN=2 reproduces the legacy 1-then-0 behaviour: high for two cycles after release, then low.
- cnt saturates at T_LAST and never wraps.
- Parameter legality is checked by elaboration-time assertions (PULSE_LEN>=1, NUM_CH>=1, STAGGER>=0).

Decomposition:
- Shared package init_seq_pkg holds:
  - the state enum typedef (RUN, FINISH, IDLE);
  - a function release_time(k, PULSE_LEN, STAGGER) returning T_k, reused by RTL and bench.
- No sub-module. Single counter, FSM and NUM_CH comparators in one module, generate loop over channels.

Test Plan:
- Defaults (T=2,5,8,11), release reset at t0 -> init_out=4'b1111 through E1; after E2 4'b1110; after E5 4'b1100; after E8 4'b1000; after E11 4'b0000 with done=1 for one cycle, busy=0.
- hold=1 for 3 edges starting after E3 -> every later release shifts by exactly 3 cycles (ch1 falls after edge 8, last after edge 14); init_out stable during hold.
- In IDLE, pulse rearm for one cycle -> next cycle init_out=4'b1111, busy=1, full sequence repeats with identical timing; rearm during RUN at E4 -> ignored, sequence unchanged.
- Assert reset (0) mid-sequence at E6 -> init_out=4'b1111 asynchronously, done=0; after release, sequence restarts from T=2.
- STAGGER=0, NUM_CH=3, PULSE_LEN=4 -> 3'b111 until E4, then 3'b000 and done pulse one cycle.
- NUM_CH=1, PULSE_LEN=2 -> init_out=1 for cycles before E1 and E1–E2, 0 after E2, done one cycle, matches legacy initialiser.
